fitness_feeder: RTL and testbench

Streaming source for `fitness_eval`. On a start pulse it optionally loads the self- and interaction-energy tables from a configuration ROM into `fitness_eval`. It then reads `POP_SIZE` individuals from population memory and drives them one per cycle with their index. It holds busy until `fitness_eval` reports completion, then pulses done to the GA controller.

---
 rtl/fitness_feeder_pkg.sv | 24 ++
 rtl/rd_stream_ctr.sv | 62 ++++++
 rtl/fitness_feeder.sv | 170 +++++++++++++++++
 tb/tb_fitness_feeder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fitness_feeder_pkg.sv
// Shared GA parameters and feeder state encoding.
// Imported by fitness_feeder and rd_stream_ctr.
package fitness_feeder_pkg;

   localparam int GA_NUM_PARTICLE_TYPE = 3;
   localparam int GA_DATA_WIDTH        = 4;
   localparam int GA_PARTICLE_LENGTH   = 2;
   localparam int GA_LATTICE_LENGTH    = 11;
   localparam int GA_INDIVIDUAL_LENGTH =
      GA_LATTICE_LENGTH * GA_PARTICLE_LENGTH;
   localparam int GA_POP_SIZE          = 50;
   localparam int GA_IDX_WIDTH         = 8;
   localparam int GA_CFG_ADDR_WIDTH    = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG,
      ST_POP,
      ST_DRAIN,
      ST_WAIT_EVAL,
      ST_DONE
   } feeder_state_e;

endpackage

// File: rtl/rd_stream_ctr.sv
// Read-address counter 0..CNT-1 with a 1-cycle-delayed valid/index pipe.
// Ports: clk_i, rst_n, start_i -> rd_en_o, addr_o, last_o, vld_o, idx_o.
module rd_stream_ctr
   import fitness_feeder_pkg::*;
#(
   parameter int CNT = 1,
   parameter int AW  = 4
) (
   input  logic          clk_i,
   input  logic          rst_n,
   input  logic          start_i,
   output logic          rd_en_o,
   output logic [AW-1:0] addr_o,
   output logic          last_o,
   output logic          vld_o,
   output logic [AW-1:0] idx_o
);

   localparam logic [AW-1:0] LAST = AW'(CNT - 1);

   logic          rd_en_q, rd_en_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          vld_q;
   logic [AW-1:0] idx_q;

   assign last_o = rd_en_q && (addr_q == LAST);

   // Address parks at 0 after the final read so it never wraps.
   always_comb begin
      rd_en_d = rd_en_q;
      addr_d  = addr_q;
      if (start_i) begin
         rd_en_d = 1'b1;
         addr_d  = '0;
      end else if (last_o) begin
         rd_en_d = 1'b0;
         addr_d  = '0;
      end else if (rd_en_q) begin
         addr_d = addr_q + AW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_q <= 1'b0;
         addr_q  <= '0;
         vld_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         rd_en_q <= rd_en_d;
         addr_q  <= addr_d;
         vld_q   <= rd_en_q;
         idx_q   <= addr_q;
      end
   end

   assign rd_en_o = rd_en_q;
   assign addr_o  = addr_q;
   assign vld_o   = vld_q;
   assign idx_o   = idx_q;

endmodule

// File: rtl/fitness_feeder.sv
// Streams energy tables and the population into fitness_eval.
// Ports: start/load in, cfg ROM + pop mem reads, eval beats out, busy/done.
module fitness_feeder
   import fitness_feeder_pkg::*;
#(
   parameter int NUM_PARTICLE_TYPE = GA_NUM_PARTICLE_TYPE,
   parameter int DATA_WIDTH        = GA_DATA_WIDTH,
   parameter int PARTICLE_LENGTH   = GA_PARTICLE_LENGTH,
   parameter int LATTICE_LENGTH    = GA_LATTICE_LENGTH,
   parameter int INDIVIDUAL_LENGTH = LATTICE_LENGTH * PARTICLE_LENGTH,
   parameter int POP_SIZE          = GA_POP_SIZE,
   parameter int IDX_WIDTH         = GA_IDX_WIDTH,
   parameter int CFG_ADDR_WIDTH    = GA_CFG_ADDR_WIDTH
) (
   input  logic                         clk_i,
   input  logic                         rst_n,
   input  logic                         start_i,
   input  logic                         load_energy_i,
   output logic                         cfg_rd_en_o,
   output logic [CFG_ADDR_WIDTH-1:0]    cfg_addr_o,
   input  logic [DATA_WIDTH-1:0]        cfg_self_data_i,
   input  logic [DATA_WIDTH-1:0]        cfg_inter_data_i,
   output logic                         pop_rd_en_o,
   output logic [IDX_WIDTH-1:0]         pop_addr_o,
   input  logic [INDIVIDUAL_LENGTH-1:0] pop_data_i,
   output logic [DATA_WIDTH-1:0]        self_energy_o,
   output logic [DATA_WIDTH-1:0]        interact_energy_o,
   output logic                         wrSelfEnergyValid_o,
   output logic                         wrInteractEnergyValid_o,
   output logic [INDIVIDUAL_LENGTH-1:0] individual_vec_o,
   output logic                         in_valid_o,
   output logic [IDX_WIDTH-1:0]         ind_idx_o,
   input  logic                         eval_done_i,
   output logic                         busy_o,
   output logic                         done_o
);

   localparam int CFG_CNT = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE;
   localparam logic [CFG_ADDR_WIDTH-1:0] SELF_CNT =
      CFG_ADDR_WIDTH'(NUM_PARTICLE_TYPE);

   feeder_state_e state_q, state_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic flag_q, flag_d;
   logic cfg_start, pop_start;

   logic                      cfg_last, cfg_vld;
   logic [CFG_ADDR_WIDTH-1:0] cfg_idx;
   logic                      pop_last, pop_vld;
   logic [IDX_WIDTH-1:0]      pop_idx;
   logic                      self_vld;

   rd_stream_ctr #(
      .CNT (CFG_CNT),
      .AW  (CFG_ADDR_WIDTH)
   ) u_cfg_ctr (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .start_i (cfg_start),
      .rd_en_o (cfg_rd_en_o),
      .addr_o  (cfg_addr_o),
      .last_o  (cfg_last),
      .vld_o   (cfg_vld),
      .idx_o   (cfg_idx)
   );

   rd_stream_ctr #(
      .CNT (POP_SIZE),
      .AW  (IDX_WIDTH)
   ) u_pop_ctr (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .start_i (pop_start),
      .rd_en_o (pop_rd_en_o),
      .addr_o  (pop_addr_o),
      .last_o  (pop_last),
      .vld_o   (pop_vld),
      .idx_o   (pop_idx)
   );

   // Population reads begin on the same edge the last config read
   // retires, so the two streams join with no bubble.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      flag_d    = flag_q;
      cfg_start = 1'b0;
      pop_start = 1'b0;
      if (eval_done_i && (state_q != ST_IDLE)) begin
         flag_d = 1'b1;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               busy_d = 1'b1;
               flag_d = 1'b0;
               if (load_energy_i) begin
                  state_d   = ST_CFG;
                  cfg_start = 1'b1;
               end else begin
                  state_d   = ST_POP;
                  pop_start = 1'b1;
               end
            end
         end
         ST_CFG: begin
            if (cfg_last) begin
               state_d   = ST_POP;
               pop_start = 1'b1;
            end
         end
         ST_POP: begin
            if (pop_last) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_d = ST_WAIT_EVAL;
         end
         ST_WAIT_EVAL: begin
            if (flag_q || eval_done_i) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         flag_q  <= flag_d;
      end
   end

   // Only the first N config words carry self energies.
   assign self_vld = cfg_vld && (cfg_idx < SELF_CNT);

   assign wrSelfEnergyValid_o     = self_vld;
   assign wrInteractEnergyValid_o = cfg_vld;
   assign in_valid_o              = pop_vld;
   assign ind_idx_o               = pop_idx;
   assign busy_o                  = busy_q;
   assign done_o                  = done_q;

   // Payloads pass straight through, masked to zero outside their beat.
   assign self_energy_o =
      cfg_self_data_i & {DATA_WIDTH{self_vld}};
   assign interact_energy_o =
      cfg_inter_data_i & {DATA_WIDTH{cfg_vld}};
   assign individual_vec_o =
      pop_data_i & {INDIVIDUAL_LENGTH{pop_vld}};

endmodule

// File: tb/tb_fitness_feeder.sv
// Directed testbench for fitness_feeder.
// Models config ROM and population memory with 1-cycle read latency.
module tb_fitness_feeder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start_i = 1'b0;
   logic        load_energy_i = 1'b0;
   logic        eval_done_i = 1'b0;
   logic        cfg_rd_en_o;
   logic [3:0]  cfg_addr_o;
   logic [3:0]  cfg_self_data_i = '0;
   logic [3:0]  cfg_inter_data_i = '0;
   logic        pop_rd_en_o;
   logic [7:0]  pop_addr_o;
   logic [21:0] pop_data_i = '0;
   logic [3:0]  self_energy_o;
   logic [3:0]  interact_energy_o;
   logic        wrSelfEnergyValid_o;
   logic        wrInteractEnergyValid_o;
   logic [21:0] individual_vec_o;
   logic        in_valid_o;
   logic [7:0]  ind_idx_o;
   logic        busy_o;
   logic        done_o;

   int checks = 0;
   int failures = 0;

   logic [3:0]  rom_self  [0:15];
   logic [3:0]  rom_inter [0:15];
   logic [21:0] pop_mem   [0:255];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cfg_rd_en_o) begin
         cfg_self_data_i  <= rom_self[cfg_addr_o];
         cfg_inter_data_i <= rom_inter[cfg_addr_o];
      end
      if (pop_rd_en_o) begin
         pop_data_i <= pop_mem[pop_addr_o];
      end
   end

   fitness_feeder dut (
      .clk_i                   (clk),
      .rst_n                   (rst_n),
      .start_i                 (start_i),
      .load_energy_i           (load_energy_i),
      .cfg_rd_en_o             (cfg_rd_en_o),
      .cfg_addr_o              (cfg_addr_o),
      .cfg_self_data_i         (cfg_self_data_i),
      .cfg_inter_data_i        (cfg_inter_data_i),
      .pop_rd_en_o             (pop_rd_en_o),
      .pop_addr_o              (pop_addr_o),
      .pop_data_i              (pop_data_i),
      .self_energy_o           (self_energy_o),
      .interact_energy_o       (interact_energy_o),
      .wrSelfEnergyValid_o     (wrSelfEnergyValid_o),
      .wrInteractEnergyValid_o (wrInteractEnergyValid_o),
      .individual_vec_o        (individual_vec_o),
      .in_valid_o              (in_valid_o),
      .ind_idx_o               (ind_idx_o),
      .eval_done_i             (eval_done_i),
      .busy_o                  (busy_o),
      .done_o                  (done_o)
   );

   // Returns at the negedge just after the start edge E0.
   task automatic do_start(input logic ld);
      @(negedge clk);
      start_i = 1'b1;
      load_energy_i = ld;
      @(negedge clk);
      start_i = 1'b0;
      load_energy_i = 1'b0;
   endtask

   // Pulses eval_done and waits (bounded) for done_o.
   task automatic finish_pass(output bit seen);
      seen = 1'b0;
      eval_done_i = 1'b1;
      @(negedge clk);
      eval_done_i = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done_o) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      logic [80:0] all_o;
      #2 rst_n = 1'b0;
      #1;
      all_o = {cfg_rd_en_o, cfg_addr_o, pop_rd_en_o, pop_addr_o,
               self_energy_o, interact_energy_o, wrSelfEnergyValid_o,
               wrInteractEnergyValid_o, individual_vec_o, in_valid_o,
               ind_idx_o, busy_o, done_o, 14'd0};
      checks++;
      if (all_o !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", all_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy_o, cfg_rd_en_o, pop_rd_en_o} !== 3'b000) begin
         failures++;
         $display("FAIL reset_idle got=%b exp=000",
                  {busy_o, cfg_rd_en_o, pop_rd_en_o});
      end
   endtask

   task automatic test_load;
      bit seen;
      int bad_cfg = 0;
      int bad_pop = 0;
      do_start(1'b1);
      checks++;
      if ({busy_o, cfg_rd_en_o, cfg_addr_o, pop_rd_en_o} !== 7'b1100000) begin
         failures++;
         $display("FAIL load_first_read got=%b exp=1100000",
                  {busy_o, cfg_rd_en_o, cfg_addr_o, pop_rd_en_o});
      end
      for (int t = 1; t <= 9; t++) begin
         @(negedge clk);
         if (wrInteractEnergyValid_o !== 1'b1 ||
             interact_energy_o !== rom_inter[t-1] ||
             wrSelfEnergyValid_o !== (t <= 3) ||
             (t <= 3 && self_energy_o !== 4'(t)) ||
             in_valid_o !== 1'b0) begin
            bad_cfg++;
            $display("FAIL cfg_beat k=%0d got iv=%b i=%0d sv=%b s=%0d",
                     t - 1, wrInteractEnergyValid_o, interact_energy_o,
                     wrSelfEnergyValid_o, self_energy_o);
         end
      end
      checks++;
      if (bad_cfg != 0) begin
         failures++;
         $display("FAIL cfg_beats got=%0d_bad exp=0_bad", bad_cfg);
      end
      for (int t = 10; t <= 59; t++) begin
         @(negedge clk);
         if (in_valid_o !== 1'b1 || ind_idx_o !== 8'(t - 10) ||
             individual_vec_o !== 22'(t - 10) ||
             wrInteractEnergyValid_o !== 1'b0) begin
            bad_pop++;
            $display("FAIL load_pop t=%0d got v=%b idx=%0d exp idx=%0d",
                     t, in_valid_o, ind_idx_o, t - 10);
         end
      end
      checks++;
      if (bad_pop != 0) begin
         failures++;
         $display("FAIL load_pop_beats got=%0d_bad exp=0_bad", bad_pop);
      end
      @(negedge clk);
      checks++;
      if (in_valid_o !== 1'b0 || busy_o !== 1'b1) begin
         failures++;
         $display("FAIL load_after_last got v=%b b=%b exp v=0 b=1",
                  in_valid_o, busy_o);
      end
      finish_pass(seen);
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL load_done got=timeout exp=done");
      end
   endtask

   task automatic test_stream_late_done;
      int bad = 0;
      do_start(1'b0);
      checks++;
      if ({busy_o, pop_rd_en_o, pop_addr_o, cfg_rd_en_o} !== 11'b11000000000) begin
         failures++;
         $display("FAIL stream_first_read got=%b exp=11000000000",
                  {busy_o, pop_rd_en_o, pop_addr_o, cfg_rd_en_o});
      end
      for (int t = 1; t <= 50; t++) begin
         @(negedge clk);
         if (in_valid_o !== 1'b1 || ind_idx_o !== 8'(t - 1) ||
             individual_vec_o !== 22'(t - 1)) begin
            bad++;
            $display("FAIL stream t=%0d got v=%b idx=%0d vec=%0d exp=%0d",
                     t, in_valid_o, ind_idx_o, individual_vec_o, t - 1);
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL stream_beats got=%0d_bad exp=0_bad", bad);
      end
      @(negedge clk);
      checks++;
      if ({in_valid_o, pop_rd_en_o} !== 2'b00) begin
         failures++;
         $display("FAIL stream_end got=%b exp=00",
                  {in_valid_o, pop_rd_en_o});
      end
      repeat (19) @(negedge clk);
      checks++;
      if ({done_o, busy_o} !== 2'b01) begin
         failures++;
         $display("FAIL late_wait got=%b exp=01", {done_o, busy_o});
      end
      eval_done_i = 1'b1;
      @(negedge clk);
      eval_done_i = 1'b0;
      checks++;
      if ({done_o, busy_o} !== 2'b10) begin
         failures++;
         $display("FAIL late_done got=%b exp=10", {done_o, busy_o});
      end
      @(negedge clk);
      checks++;
      if ({done_o, busy_o} !== 2'b00) begin
         failures++;
         $display("FAIL late_after got=%b exp=00", {done_o, busy_o});
      end
   endtask

   task automatic test_early_done;
      int bad = 0;
      do_start(1'b0);
      for (int t = 1; t <= 50; t++) begin
         if (t == 5) eval_done_i = 1'b1;
         if (t == 6) eval_done_i = 1'b0;
         @(negedge clk);
         if (in_valid_o !== 1'b1 || ind_idx_o !== 8'(t - 1) ||
             done_o !== 1'b0) begin
            bad++;
            $display("FAIL early_stream t=%0d got v=%b idx=%0d d=%b",
                     t, in_valid_o, ind_idx_o, done_o);
         end
      end
      eval_done_i = 1'b0;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL early_beats got=%0d_bad exp=0_bad", bad);
      end
      @(negedge clk);
      checks++;
      if ({done_o, busy_o} !== 2'b01) begin
         failures++;
         $display("FAIL early_drain got=%b exp=01", {done_o, busy_o});
      end
      @(negedge clk);
      checks++;
      if ({done_o, busy_o} !== 2'b10) begin
         failures++;
         $display("FAIL early_done got=%b exp=10", {done_o, busy_o});
      end
   endtask

   task automatic test_back_to_back;
      int bad = 0;
      @(negedge clk);
      do_start(1'b0);
      for (int t = 1; t <= 50; t++) begin
         if (t == 10) start_i = 1'b1;
         if (t == 11) start_i = 1'b0;
         @(negedge clk);
         if (in_valid_o !== 1'b1 || ind_idx_o !== 8'(t - 1) ||
             (t < 50 && pop_addr_o !== 8'(t)) ||
             cfg_rd_en_o !== 1'b0) begin
            bad++;
            $display("FAIL restart t=%0d got idx=%0d addr=%0d exp=%0d",
                     t, ind_idx_o, pop_addr_o, t - 1);
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL restart_beats got=%0d_bad exp=0_bad", bad);
      end
      @(negedge clk);
      eval_done_i = 1'b1;
      @(negedge clk);
      eval_done_i = 1'b0;
      checks++;
      if (done_o !== 1'b1) begin
         failures++;
         $display("FAIL restart_done got=%b exp=1", done_o);
      end
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if ({busy_o, pop_rd_en_o, cfg_rd_en_o} !== 3'b000) begin
         failures++;
         $display("FAIL start_in_done got=%b exp=000",
                  {busy_o, pop_rd_en_o, cfg_rd_en_o});
      end
      @(negedge clk);
      checks++;
      if ({busy_o, pop_rd_en_o, in_valid_o} !== 3'b000) begin
         failures++;
         $display("FAIL start_in_done_2 got=%b exp=000",
                  {busy_o, pop_rd_en_o, in_valid_o});
      end
   endtask

   task automatic test_reset_mid;
      bit seen;
      int bad = 0;
      do_start(1'b0);
      repeat (26) @(negedge clk);
      checks++;
      if (in_valid_o !== 1'b1 || ind_idx_o !== 8'd25) begin
         failures++;
         $display("FAIL mid_before got v=%b idx=%0d exp v=1 idx=25",
                  in_valid_o, ind_idx_o);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_valid_o, ind_idx_o, individual_vec_o, pop_rd_en_o,
           pop_addr_o, busy_o, done_o} !== '0) begin
         failures++;
         $display("FAIL mid_reset got v=%b idx=%0d rd=%b a=%0d b=%b d=%b",
                  in_valid_o, ind_idx_o, pop_rd_en_o, pop_addr_o,
                  busy_o, done_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      eval_done_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         eval_done_i = 1'b0;
         if ({in_valid_o, pop_rd_en_o, busy_o, done_o} !== 4'b0000) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL mid_quiet got=%0d_bad exp=0_bad", bad);
      end
      do_start(1'b0);
      checks++;
      if ({pop_rd_en_o, pop_addr_o} !== 9'b100000000) begin
         failures++;
         $display("FAIL mid_restart_addr got rd=%b a=%0d exp rd=1 a=0",
                  pop_rd_en_o, pop_addr_o);
      end
      @(negedge clk);
      checks++;
      if (in_valid_o !== 1'b1 || ind_idx_o !== 8'd0 ||
          individual_vec_o !== 22'd0) begin
         failures++;
         $display("FAIL mid_restart_beat got v=%b idx=%0d exp v=1 idx=0",
                  in_valid_o, ind_idx_o);
      end
      finish_pass(seen);
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL mid_restart_done got=timeout exp=done");
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         rom_self[i]  = 4'hF;
         rom_inter[i] = 4'h0;
      end
      rom_self[0] = 4'd1;
      rom_self[1] = 4'd2;
      rom_self[2] = 4'd3;
      rom_inter[0] = 4'd10; rom_inter[1] = 4'd4;  rom_inter[2] = 4'd1;
      rom_inter[3] = 4'd4;  rom_inter[4] = 4'd10; rom_inter[5] = 4'd5;
      rom_inter[6] = 4'd1;  rom_inter[7] = 4'd5;  rom_inter[8] = 4'd10;
      for (int i = 0; i < 256; i++) pop_mem[i] = 22'(i);

      test_reset();
      test_load();
      test_stream_late_done();
      test_early_done();
      test_back_to_back();
      test_reset_mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
